// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared constants and helpers for the scanned seven-segment display
package display_pkg;

    localparam int NUM_DIGITS_DEF = 4;

    // Segment bus is active-low; a set bit in these masks marks a lit segment before inversion.
    localparam logic [6:0] SEG_A = 7'b1000000;
    localparam logic [6:0] SEG_B = 7'b0100000;
    localparam logic [6:0] SEG_C = 7'b0010000;
    localparam logic [6:0] SEG_D = 7'b0001000;
    localparam logic [6:0] SEG_E = 7'b0000100;
    localparam logic [6:0] SEG_F = 7'b0000010;
    localparam logic [6:0] SEG_G = 7'b0000001;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic       ANODE_OFF = 1'b1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/binary_to_segment.sv
// rtl/binary_to_segment.sv - hex digit to active-low ABCDEFG segment decoder
module binary_to_segment
    import display_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    logic [6:0] lit;

    // Pick the lit segments for each hex glyph, then invert for the common-anode bus.
    always_comb begin
        lit = '0;
        case (digit)
            4'h0: lit = SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F;
            4'h1: lit = SEG_B | SEG_C;
            4'h2: lit = SEG_A | SEG_B | SEG_D | SEG_E | SEG_G;
            4'h3: lit = SEG_A | SEG_B | SEG_C | SEG_D | SEG_G;
            4'h4: lit = SEG_B | SEG_C | SEG_F | SEG_G;
            4'h5: lit = SEG_A | SEG_C | SEG_D | SEG_F | SEG_G;
            4'h6: lit = SEG_A | SEG_C | SEG_D | SEG_E | SEG_F | SEG_G;
            4'h7: lit = SEG_A | SEG_B | SEG_C;
            4'h8: lit = SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F | SEG_G;
            4'h9: lit = SEG_A | SEG_B | SEG_C | SEG_D | SEG_F | SEG_G;
            4'hA: lit = SEG_A | SEG_B | SEG_C | SEG_E | SEG_F | SEG_G;
            4'hB: lit = SEG_C | SEG_D | SEG_E | SEG_F | SEG_G;
            4'hC: lit = SEG_A | SEG_D | SEG_E | SEG_F;
            4'hD: lit = SEG_B | SEG_C | SEG_D | SEG_E | SEG_G;
            4'hE: lit = SEG_A | SEG_D | SEG_E | SEG_F | SEG_G;
            default: lit = SEG_A | SEG_E | SEG_F | SEG_G;
        endcase
        seg = ~lit;
    end

endmodule

// File: rtl/seven_segment_scan_controller.sv
// rtl/seven_segment_scan_controller.sv - multiplexed hex display scanner with frame-aligned updates
module seven_segment_scan_controller
    import display_pkg::*;
#(
    parameter  int NUM_DIGITS   = NUM_DIGITS_DEF,
    parameter  int REFRESH_DIV  = 50000,
    parameter  int BLANK_CYCLES = 2,
    parameter  int DIV_W        = 16,
    localparam int IDX_W        = (clog2(NUM_DIGITS) > 0) ? clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic                    lz_suppress,
    output logic                    load_ack,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [6:0]              seven,
    output logic [IDX_W-1:0]        digit_idx
);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
    localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [DIV_W-1:0]        div;
    logic                    div_wrap;
    logic                    frame_end;

    logic [4*NUM_DIGITS-1:0] pend_val;
    logic [NUM_DIGITS-1:0]   pend_mask;
    logic                    pend_valid;
    logic [4*NUM_DIGITS-1:0] disp_val;
    logic [NUM_DIGITS-1:0]   disp_mask;

    logic [NUM_DIGITS-1:0]   dark;
    logic                    upper_zero;
    logic [3:0]              cur_digit;
    logic                    cur_dark;
    logic [NUM_DIGITS-1:0]   cur_anode;
    logic [6:0]              cur_seg;

    assign div_wrap  = (div == DIV_LAST);
    assign frame_end = div_wrap && (digit_idx == IDX_LAST);

    // Slot divider and digit index, both wrapping explicitly at their terminal counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            div       <= '0;
            digit_idx <= '0;
        end else if (div_wrap) begin
            div       <= '0;
            digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
        end else begin
            div       <= div + 1'b1;
        end
    end

    // Pending/commit: new values wait for the frame boundary; a load on the boundary itself commits directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_val   <= '0;
            pend_mask  <= '0;
            pend_valid <= 1'b0;
            disp_val   <= '0;
            disp_mask  <= '1;
            load_ack   <= 1'b0;
        end else begin
            load_ack <= 1'b0;
            if (load && frame_end) begin
                disp_val   <= value;
                disp_mask  <= blank_mask;
                pend_valid <= 1'b0;
                load_ack   <= 1'b1;
            end else if (load) begin
                pend_val   <= value;
                pend_mask  <= blank_mask;
                pend_valid <= 1'b1;
            end else if (frame_end && pend_valid) begin
                disp_val   <= pend_val;
                disp_mask  <= pend_mask;
                pend_valid <= 1'b0;
                load_ack   <= 1'b1;
            end
        end
    end

    // Dark digits: explicit mask, plus leading zeros scanned from the top digit down (digit 0 always kept).
    always_comb begin
        dark       = disp_mask;
        upper_zero = 1'b1;
        for (int d = NUM_DIGITS - 1; d > 0; d--) begin
            upper_zero = upper_zero && (disp_val[4*d +: 4] == 4'h0);
            if (lz_suppress && upper_zero) begin
                dark[d] = 1'b1;
            end
        end
    end

    // Digit-select mux feeding the shared decoder, plus the one-hot-low anode for the current slot.
    always_comb begin
        cur_digit = 4'h0;
        cur_dark  = 1'b1;
        cur_anode = {NUM_DIGITS{ANODE_OFF}};
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (digit_idx == IDX_W'(d)) begin
                cur_digit    = disp_val[4*d +: 4];
                cur_dark     = dark[d];
                cur_anode[d] = ~ANODE_OFF;
            end
        end
    end

    binary_to_segment u_decoder (
        .digit (cur_digit),
        .seg   (cur_seg)
    );

    // Registered output stage: anti-ghost blanking at slot start, dark digits fully off.
    always_ff @(posedge clk) begin
        if (rst) begin
            anode <= {NUM_DIGITS{ANODE_OFF}};
            seven <= SEG_BLANK;
        end else if ((div < BLANK_END) || cur_dark) begin
            anode <= {NUM_DIGITS{ANODE_OFF}};
            seven <= SEG_BLANK;
        end else begin
            anode <= cur_anode;
            seven <= cur_seg;
        end
    end

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// tb/tb_seven_segment_scan_controller.sv - scoreboard bench for the seven-segment scan controller
module tb_seven_segment_scan_controller;

    localparam int N     = 4;
    localparam int RDIV  = 4;
    localparam int BLANK = 1;
    localparam int FRAME = N * RDIV;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic [3:0]  bmask;
    logic        lz;
    logic        load_ack;
    logic [3:0]  anode;
    logic [6:0]  seven;
    logic [1:0]  digit_idx;

    always #5 clk = ~clk;

    seven_segment_scan_controller #(
        .NUM_DIGITS   (N),
        .REFRESH_DIV  (RDIV),
        .BLANK_CYCLES (BLANK),
        .DIV_W        (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .value       (value),
        .blank_mask  (bmask),
        .lz_suppress (lz),
        .load_ack    (load_ack),
        .anode       (anode),
        .seven       (seven),
        .digit_idx   (digit_idx)
    );

    typedef struct packed {
        logic [3:0] anode;
        logic [6:0] seven;
        logic       ack;
        logic [1:0] idx;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;
    int   ack_seen = 0;

    // Reference model state: position within the frame, displayed and pending contents.
    int          m_cnt = 0;
    logic [15:0] m_disp, m_pend;
    logic [3:0]  m_mask, m_pmask;
    bit          m_pv, m_ack;
    bit          m_valid = 0;
    int          md, mphase;
    bit          mfb, mdark;
    exp_t        me, mon;

    function automatic logic [6:0] glyph(input int v);
        logic [6:0] hi [16];
        hi = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
               7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
        return ~hi[v & 15];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    // Model: predict the registered outputs from the frame position and push them to the scoreboard.
    always @(posedge clk) begin
        if (rst) begin
            m_cnt  = 0;
            m_disp = '0;
            m_mask = 4'hF;
            m_pv   = 0;
            m_ack  = 0;
            me     = '{anode: 4'hF, seven: 7'h7F, ack: 1'b0, idx: 2'd0};
            m_valid = 1;
        end else if (m_valid) begin
            md     = m_cnt / RDIV;
            mphase = m_cnt % RDIV;
            mfb    = (m_cnt == FRAME - 1);
            mdark  = m_mask[md] || (lz && md > 0 && (m_disp >> (4 * md)) == 16'h0);
            if (mphase < BLANK || mdark) begin
                me.anode = 4'hF;
                me.seven = 7'h7F;
            end else begin
                me.anode = 4'(~(1 << md));
                me.seven = glyph(int'((m_disp >> (4 * md)) & 16'hF));
            end
            m_ack = 0;
            if (load && mfb) begin
                m_disp = value; m_mask = bmask; m_pv = 0; m_ack = 1;
            end else if (load) begin
                m_pend = value; m_pmask = bmask; m_pv = 1;
            end else if (mfb && m_pv) begin
                m_disp = m_pend; m_mask = m_pmask; m_pv = 0; m_ack = 1;
            end
            me.ack = m_ack;
            m_cnt  = (m_cnt + 1) % FRAME;
            me.idx = 2'(m_cnt / RDIV);
        end
        if (m_valid) expq.push_back(me);
    end

    // Monitor: every cycle the DUT presents outputs, pop the prediction and compare.
    always @(negedge clk) begin
        if (expq.size() > 0) begin
            mon = expq.pop_front();
            chk("anode", 32'(anode), 32'(mon.anode));
            chk("seven", 32'(seven), 32'(mon.seven));
            chk("load_ack", 32'(load_ack), 32'(mon.ack));
            chk("digit_idx", 32'(digit_idx), 32'(mon.idx));
            chk("one_anode_low", 32'($countones(~anode) <= 1), 32'd1);
            if (load_ack === 1'b1) ack_seen++;
        end
    end

    task automatic wait_cnt(input int target);
        int i;
        for (i = 0; i < 64; i++) begin
            if (m_cnt == target) break;
            @(negedge clk);
        end
        if (i == 64) begin
            checks++;
            errors++;
            $display("FAIL wait_cnt actual=%0d required=%0d", m_cnt, target);
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] m);
        load  = 1'b1;
        value = v;
        bmask = m;
        @(negedge clk);
        load  = 1'b0;
    endtask

    int a0;

    initial begin
        rst = 1'b1; load = 1'b0; value = '0; bmask = '0; lz = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_anode", 32'(anode), 32'hF);
        chk("reset_seven", 32'(seven), 32'h7F);
        chk("reset_ack", 32'(load_ack), 32'h0);
        chk("reset_idx", 32'(digit_idx), 32'h0);
        rst = 1'b0;

        // Plain scan of 1234.
        wait_cnt(5);
        a0 = ack_seen;
        do_load(16'h1234, 4'h0);
        repeat (2 * FRAME) @(negedge clk);
        chk("scan_ack_count", 32'(ack_seen - a0), 32'd1);

        // Tear-free overwrite before the boundary.
        wait_cnt(2);
        a0 = ack_seen;
        do_load(16'h1234, 4'h0);
        wait_cnt(9);
        do_load(16'hABCD, 4'h0);
        repeat (2 * FRAME) @(negedge clk);
        chk("tearfree_ack_count", 32'(ack_seen - a0), 32'd1);

        // Load exactly on the frame boundary.
        wait_cnt(FRAME - 1);
        do_load(16'h00F0, 4'h0);
        chk("fb_collision_ack", 32'(load_ack), 32'h1);
        repeat (FRAME + 3) @(negedge clk);

        // Leading-zero suppression.
        lz = 1'b1;
        wait_cnt(4);
        do_load(16'h0050, 4'h0);
        repeat (2 * FRAME) @(negedge clk);
        do_load(16'h0000, 4'h0);
        repeat (2 * FRAME) @(negedge clk);
        lz = 1'b0;

        // Randomized loads, masks and live zero suppression.
        for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(0, 20)) @(negedge clk);
            lz = 1'($urandom_range(0, 1));
            do_load(16'($urandom & ((k % 3 == 0) ? 32'h00FF : 32'hFFFF)),
                    ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
        end
        repeat (2 * FRAME) @(negedge clk);

        // Reset mid-frame with a load pending.
        wait_cnt(3);
        do_load(16'h9876, 4'h0);
        wait_cnt(2 * RDIV + 2);
        a0 = ack_seen;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_anode", 32'(anode), 32'hF);
        chk("midrst_seven", 32'(seven), 32'h7F);
        chk("midrst_ack", 32'(load_ack), 32'h0);
        chk("midrst_idx", 32'(digit_idx), 32'h0);
        repeat (2 * FRAME) @(negedge clk);
        chk("midrst_no_ack", 32'(ack_seen - a0), 32'd0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
